// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the issue/hazard controller: controller state
// encodings, register index width and the widths of the buses this block
// drives toward FE and DE.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  // Default PC width, used only to size the FE-facing bus constant below.
  localparam int DEF_DBITS = 32;

  // FE sees {fe_stall, fe_redirect, fe_redirect_pc}.
  localparam int FROM_HZ_TO_FE_W = 2 + DEF_DBITS;

  // DE sees {de_stall, de_issue, de_flush}.
  localparam int FROM_HZ_TO_DE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BR_PEND  = 2'd1,
    ST_REDIRECT = 2'd2
  } hz_state_e;

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_hz_scoreboard.sv
// Per-register scoreboard of in-flight writes. Each architectural register
// (x0 excluded) has a small counter of issued-but-not-retired writers.
// Hazard lookups use the counts as they stand before the clock edge, so a
// retirement in the same cycle does not bypass a RAW stall.
module hz_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic                 i_rs1_used,
  input  logic [REG_IDX_W-1:0] i_rs2,
  input  logic                 i_rs2_used,
  input  logic                 i_wr_reg,
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic                 i_inc,
  input  logic                 i_dec,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  output logic                 o_raw_hazard,
  output logic                 o_struct_hazard,
  output logic                 o_underflow
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [NUM_REGS];

  logic w_inc_en;
  logic w_dec_en;
  logic w_same_reg;
  logic w_rs1_busy;
  logic w_rs2_busy;

  assign w_inc_en   = i_inc && (i_rd != '0);
  assign w_dec_en   = i_dec && (i_wb_rd != '0);
  // Issue and retirement on the same register cancel out.
  assign w_same_reg = w_inc_en && w_dec_en && (i_rd == i_wb_rd);

  assign w_rs1_busy = i_rs1_used && (i_rs1 != '0) && (r_cnt[i_rs1] != '0);
  assign w_rs2_busy = i_rs2_used && (i_rs2 != '0) && (r_cnt[i_rs2] != '0);

  assign o_raw_hazard    = w_rs1_busy || w_rs2_busy;
  // A full counter blocks another writer, so the counter can never wrap.
  assign o_struct_hazard = i_wr_reg && (i_rd != '0) && (r_cnt[i_rd] == LP_CNT_MAX);
  assign o_underflow     = w_dec_en && !w_same_reg && (r_cnt[i_wb_rd] == '0);

  // Counter array update: +1 on issue, -1 on retirement, floor at zero.
  // NOTE: this array is pipeline state, not storage -- a stale count after
  // reset would stall forever, so every entry is cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_inc_en && !w_same_reg && (i_rd == REG_IDX_W'(i))) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec_en && !w_same_reg && (i_wb_rd == REG_IDX_W'(i)) &&
                     (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule : hz_scoreboard

// File: rtl/pipe_hazard_ctrl.sv
// Issue/hazard controller between FE, DE and AGEX. Stalls DE on RAW and
// scoreboard-full hazards, holds fetch while a control transfer is in
// flight, and emits a one-cycle redirect plus DE flush on a taken resolve.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int DBITS    = 32,
  parameter int PERF_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REG_IDX_W-1:0] de_rs1,
  input  logic [REG_IDX_W-1:0] de_rs2,
  input  logic                 de_rs1_used,
  input  logic                 de_rs2_used,
  input  logic                 de_wr_reg,
  input  logic [REG_IDX_W-1:0] de_rd,
  input  logic                 de_is_branch,
  input  logic                 agex_br_resolved,
  input  logic                 agex_br_taken,
  input  logic [DBITS-1:0]     agex_br_target,
  input  logic                 wb_valid,
  input  logic                 wb_wr_reg,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic                 de_stall,
  output logic                 de_issue,
  output logic                 fe_stall,
  output logic                 fe_redirect,
  output logic [DBITS-1:0]     fe_redirect_pc,
  output logic                 de_flush,
  output logic [PERF_W-1:0]    stall_cycles,
  output logic                 proto_err
);

  hz_state_e         r_state;
  logic              r_fe_redirect;
  logic [DBITS-1:0]  r_fe_redirect_pc;
  logic              r_de_flush;
  logic [PERF_W-1:0] r_stall_cycles;
  logic              r_proto_err;

  logic w_raw_hazard;
  logic w_struct_hazard;
  logic w_underflow;

  hz_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk             (clk),
    .reset           (reset),
    .i_rs1           (de_rs1),
    .i_rs1_used      (de_rs1_used),
    .i_rs2           (de_rs2),
    .i_rs2_used      (de_rs2_used),
    .i_wr_reg        (de_wr_reg),
    .i_rd            (de_rd),
    .i_inc           (de_issue && de_wr_reg),
    .i_dec           (wb_valid && wb_wr_reg),
    .i_wb_rd         (wb_rd),
    .o_raw_hazard    (w_raw_hazard),
    .o_struct_hazard (w_struct_hazard),
    .o_underflow     (w_underflow)
  );

  // DE hold: hazards while idle, unconditional while a control op is open.
  // NOTE: the default assignment first means every path drives de_stall,
  // so no latch is inferred; combinational blocks use blocking '='.
  always_comb begin
    de_stall = 1'b0;
    case (r_state)
      ST_IDLE:     de_stall = w_raw_hazard || w_struct_hazard;
      ST_BR_PEND:  de_stall = 1'b1;
      ST_REDIRECT: de_stall = 1'b1;
      default:     de_stall = 1'b1;
    endcase
  end

  assign de_issue       = de_valid && !de_stall;
  assign fe_stall       = (r_state == ST_BR_PEND);
  assign fe_redirect    = r_fe_redirect;
  assign fe_redirect_pc = r_fe_redirect_pc;
  assign de_flush       = r_de_flush;
  assign stall_cycles   = r_stall_cycles;
  assign proto_err      = r_proto_err;

  // Control-transfer sequencer with registered redirect/flush outputs.
  // NOTE: state registers use non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_fe_redirect    <= 1'b0;
      r_fe_redirect_pc <= '0;
      r_de_flush       <= 1'b0;
    end else begin
      r_fe_redirect <= 1'b0;
      r_de_flush    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (de_issue && de_is_branch) r_state <= ST_BR_PEND;
        end
        ST_BR_PEND: begin
          if (agex_br_resolved) begin
            if (agex_br_taken) begin
              r_state          <= ST_REDIRECT;
              r_fe_redirect    <= 1'b1;
              r_de_flush       <= 1'b1;
              r_fe_redirect_pc <= agex_br_target;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_REDIRECT: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of cycles in which a valid DE instruction is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (de_valid && de_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Sticky protocol error: stray resolve or retirement of an idle register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_proto_err <= 1'b0;
    end else if (w_underflow || (agex_br_resolved && (r_state != ST_BR_PEND))) begin
      r_proto_err <= 1'b1;
    end
  end

endmodule : pipe_hazard_ctrl

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Issue/hazard controller sitting between FE, DE and AGEX of the 5-stage RV32I pipeline. It keeps a per-register scoreboard of in-flight writes and stalls DE on RAW hazards. It sequences control transfers: it holds fetch while a branch or jump is outstanding, then issues a one-cycle redirect and DE flush when AGEX resolves it taken. Replaces the ad-hoc `is_branch`-driven stall wiring between AGEX and DE.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers tracked (x0 never tracked)
- CNT_W, 2, width of each per-register in-flight write counter
- DBITS, 32, PC width
- PERF_W, 32, stall-cycle counter width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- de_valid  in  1  DE holds an instruction requesting issue
- de_rs1, de_rs2  in  5 each  source register indices
- de_rs1_used, de_rs2_used  in  1 each  source actually read
- de_wr_reg  in  1  instruction writes rd
- de_rd  in  5  destination index
- de_is_branch  in  1  instruction is a branch, JAL or JALR
- agex_br_resolved  in  1  AGEX resolves the outstanding control op this cycle
- agex_br_taken  in  1  resolved taken (valid with agex_br_resolved)
- agex_br_target  in  DBITS  redirect PC (valid with agex_br_resolved)
- wb_valid  in  1  WB retires an instruction
- wb_wr_reg  in  1  retiring instruction writes rd
- wb_rd  in  5  retiring destination
- de_stall  out  1  DE must hold (combinational)
- de_issue  out  1  de_valid & ~de_stall (combinational)
- fe_stall  out  1  FE must hold PC (combinational from state)
- fe_redirect  out  1  registered one-cycle redirect pulse
- fe_redirect_pc  out  DBITS  registered target; holds last value
- de_flush  out  1  registered; kill instruction in DE latch
- stall_cycles  out  PERF_W  saturating count of cycles with de_valid & de_stall
- proto_err  out  1  sticky protocol error

## Operation
- Scoreboard: cnt[r] per register r=1..NUM_REGS-1. On a clock edge, de_issue & de_wr_reg & de_rd≠0 increments cnt[de_rd]. wb_valid & wb_wr_reg & wb_rd≠0 decrements cnt[wb_rd]. Both on the same register: no change.
- RAW hazard: (de_rs1_used & cnt[de_rs1]≠0) | (de_rs2_used & cnt[de_rs2]≠0). Index 0 never hazards. Evaluated on pre-edge counts; no same-cycle WB bypass.
- Structural hazard: de_wr_reg & de_rd≠0 & cnt[de_rd]=2^CNT_W−1 stalls. No counter overflow is possible.
- Decrement of a zero counter: counter stays 0 and proto_err sets.
- FSM states:
  - IDLE: de_stall = hazards; fe_stall = 0. de_issue & de_is_branch → BR_PEND.
  - BR_PEND: de_stall = 1; fe_stall = 1. agex_br_resolved & taken → REDIRECT. agex_br_resolved & ~taken → IDLE.
  - REDIRECT: one cycle. fe_redirect = 1, fe_redirect_pc = captured target, de_flush = 1, de_stall = 1, fe_stall = 0. → IDLE.
- agex_br_resolved outside BR_PEND is ignored and sets proto_err.
- A flushed DE instruction never reaches de_issue, so the scoreboard is unaffected.
- stall_cycles saturates at all-ones.

## Timing
- Reset values: state IDLE, all cnt 0, fe_redirect 0, fe_redirect_pc 0, de_flush 0, stall_cycles 0, proto_err 0. Consequently de_stall = 0 and fe_stall = 0.
- Branch issued in cycle t: BR_PEND from t+1, so fe_stall = 1 at t+1.
- Resolve in cycle t, taken: fe_redirect, de_flush and fe_redirect_pc are valid in t+1. Normal issue resumes at t+2.
- Resolve in cycle t, not taken: IDLE at t+1, stalls drop at t+1.
- Hazard cleared by WB at edge t: the dependent instruction issues in cycle t (post-edge).
- Reset asserted mid-operation: immediate return to reset values, with no pending redirect.

## Structure
- Shared package / define.vh: FSM state encodings (IDLE, BR_PEND, REDIRECT), REG_IDX_W=5, and a from_HZ_to_FE / from_HZ_to_DE bus width.
- One sub-module: hz_scoreboard, holding the counter array, inc/dec logic, hazard lookups and the underflow flag. FSM, redirect registers and perf counter stay in the top.

## Test plan
- Scoreboard RAW: issue ADD x5 at cycle 1, dependent ADD reading x5 at cycle 2. Expect de_stall = 1 until the cycle after the WB edge retiring x5, then de_issue = 1. stall_cycles equals the stalled cycle count.
- x0 and simultaneous events: a write to x0 never stalls. Same-cycle issue and WB to x7 with cnt[7] = 1 leaves cnt[7] = 1.
- Saturation: three outstanding writes to x3 (CNT_W = 2). A fourth writer to x3 stalls until one WB, and proto_err stays 0.
- Taken branch: issue BEQ, then resolve taken with target 0x0000_0100 two cycles later. Expect exactly one cycle of fe_redirect = 1 with fe_redirect_pc = 0x100 and de_flush = 1, then IDLE.
- Not-taken JAL-less branch: resolve with taken = 0. Expect no fe_redirect, and fe_stall = 0 in the following cycle.
- Errors and reset: agex_br_resolved in IDLE sets proto_err. WB of x9 with cnt[9] = 0 sets proto_err. Drop reset while in BR_PEND: all outputs at reset values within the same cycle.
